// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the Mastermind grading stage.
// Shape codes, slot geometry and grader state encoding.
package mastermind_pkg;

    localparam int SLOTS   = 4;
    localparam int SHAPE_W = 3;
    localparam int PAT_W   = SLOTS * SHAPE_W;

    typedef enum logic [SHAPE_W-1:0] {
        SH_0 = 3'd0,
        SH_1 = 3'd1,
        SH_2 = 3'd2,
        SH_3 = 3'd3,
        SH_4 = 3'd4,
        SH_5 = 3'd5,
        SH_6 = 3'd6,
        SH_7 = 3'd7
    } shape_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } grader_state_e;

    function automatic logic [2:0] popcount4(input logic [SLOTS-1:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]}
             + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [2:0] min3(input logic [2:0] a,
                                        input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

    // Codes 0 and 7 are reserved (blank/unused) on the key front end.
    function automatic logic has_bad_shape(input logic [PAT_W-1:0] p);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            if (p[k*SHAPE_W +: SHAPE_W] == SH_0 ||
                p[k*SHAPE_W +: SHAPE_W] == SH_7)
                bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/shape_tally.sv
// Counts pattern slots holding a given shape, skipping masked slots.
// Purely combinational; one copy for the guess, one for the master.
module shape_tally
    import mastermind_pkg::*;
(
    input  logic [PAT_W-1:0]   pattern_i,
    input  logic [SLOTS-1:0]   excl_i,
    input  logic [SHAPE_W-1:0] shape_i,
    output logic [2:0]         count_o
);

    // Sum the non-excluded slots whose code equals shape_i.
    always_comb begin
        count_o = 3'd0;
        for (int k = 0; k < SLOTS; k++) begin
            if (!excl_i[k] && pattern_i[k*SHAPE_W +: SHAPE_W] == shape_i)
                count_o = count_o + 3'd1;
        end
    end

endmodule

// File: rtl/mastermind_grader.sv
// Multi-cycle Mastermind grader: exact (znarly) and shape-only (zood) matches.
// Optional macro GRADER_SHAPE_VALIDATE_EN rejects guesses holding code 0 or 7.
module mastermind_grader
    import mastermind_pkg::*;
#(
    parameter int MAX_ROUNDS = 8
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             clear_game,
    input  logic             grade,
    input  logic [PAT_W-1:0] guess,
    input  logic [PAT_W-1:0] master_pattern,
    output logic             busy,
    output logic             done,
    output logic [3:0]       znarly,
    output logic [3:0]       zood,
    output logic [3:0]       round_number,
    output logic             game_won,
    output logic             game_over,
    output logic             bad_guess
);

    grader_state_e state_q, state_d;

    logic [PAT_W-1:0]   guess_q, master_q;
    logic [SHAPE_W-1:0] shape_q;
    logic [3:0]         znarly_acc_q, zood_acc_q;
    logic [3:0]         znarly_q, zood_q, round_q;
    logic               won_q, over_q;

    logic               kill, start;
    logic [SLOTS-1:0]   eq;
    logic [2:0]         cg, cm;
    logic [3:0]         zood_sum, round_next;

    assign kill = !reset_L || clear_game;

`ifdef GRADER_SHAPE_VALIDATE_EN
    logic bad_q;
    logic reject;
    assign reject = (state_q == IDLE) && grade && !over_q
                  && has_bad_shape(guess);
    assign start  = (state_q == IDLE) && grade && !over_q
                  && !has_bad_shape(guess);
    assign bad_guess = bad_q;

    // One-cycle rejection pulse for a guess holding a reserved code.
    always_ff @(posedge clock) begin
        if (kill) bad_q <= 1'b0;
        else      bad_q <= reject;
    end
`else
    assign start     = (state_q == IDLE) && grade && !over_q;
    assign bad_guess = 1'b0;
`endif

    // Exact-match mask over the captured patterns.
    always_comb begin
        eq = '0;
        for (int k = 0; k < SLOTS; k++)
            eq[k] = guess_q[k*SHAPE_W +: SHAPE_W]
                 == master_q[k*SHAPE_W +: SHAPE_W];
    end

    shape_tally u_tally_guess (
        .pattern_i (guess_q),
        .excl_i    (eq),
        .shape_i   (shape_q),
        .count_o   (cg)
    );

    shape_tally u_tally_master (
        .pattern_i (master_q),
        .excl_i    (eq),
        .shape_i   (shape_q),
        .count_o   (cm)
    );

    assign zood_sum   = zood_acc_q + {1'b0, min3(cg, cm)};
    assign round_next = (round_q == 4'hF) ? round_q : round_q + 4'd1;

    // State register; clear and reset abort any grade in flight.
    always_ff @(posedge clock) begin
        if (kill) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: one exact pass, eight shape passes, one result cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = EXACT;
            EXACT: state_d = COUNT;
            COUNT: if (shape_q == SH_7) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state_q == EXACT) || (state_q == COUNT);
        done = (state_q == DONE);
    end

    // Datapath: capture, accumulate, and publish results at the last pass.
    always_ff @(posedge clock) begin
        if (kill) begin
            guess_q      <= '0;
            master_q     <= '0;
            shape_q      <= '0;
            znarly_acc_q <= '0;
            zood_acc_q   <= '0;
            znarly_q     <= '0;
            zood_q       <= '0;
            round_q      <= '0;
            won_q        <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            if (start) begin
                guess_q  <= guess;
                master_q <= master_pattern;
            end
            if (state_q == EXACT) begin
                znarly_acc_q <= {1'b0, popcount4(eq)};
                zood_acc_q   <= '0;
                shape_q      <= SH_0;
            end
            if (state_q == COUNT) begin
                zood_acc_q <= zood_sum;
                shape_q    <= shape_q + 3'd1;
                if (shape_q == SH_7) begin
                    znarly_q <= znarly_acc_q;
                    zood_q   <= zood_sum;
                    round_q  <= round_next;
                    if (znarly_acc_q == 4'd4)
                        won_q <= 1'b1;
                    if (znarly_acc_q == 4'd4 ||
                        round_next == 4'(MAX_ROUNDS))
                        over_q <= 1'b1;
                end
            end
        end
    end

    assign znarly       = znarly_q;
    assign zood         = zood_q;
    assign round_number = round_q;
    assign game_won     = won_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_mastermind_grader.sv
// Self-checking bench for mastermind_grader: behavioural model plus
// directed scenarios and randomized grade/clear/reset traffic.
module tb_mastermind_grader;

    localparam int MAXR = 8;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        clear_game = 1'b0;
    logic        grade = 1'b0;
    logic [11:0] guess = '0;
    logic [11:0] master = '0;
    logic        busy, done, game_won, game_over, bad_guess;
    logic [3:0]  znarly, zood, round_number;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mastermind_grader #(.MAX_ROUNDS(MAXR)) dut (
        .clock          (clk),
        .reset_L        (reset_L),
        .clear_game     (clear_game),
        .grade          (grade),
        .guess          (guess),
        .master_pattern (master),
        .busy           (busy),
        .done           (done),
        .znarly         (znarly),
        .zood           (zood),
        .round_number   (round_number),
        .game_won       (game_won),
        .game_over      (game_over),
        .bad_guess      (bad_guess)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Classic scoring: total shared shapes minus exact hits.
    function automatic void score(input logic [11:0] g, input logic [11:0] m,
                                  output int zn, output int zd);
        int cg[8];
        int cm[8];
        for (int s = 0; s < 8; s++) begin
            cg[s] = 0;
            cm[s] = 0;
        end
        zn = 0;
        zd = 0;
        for (int k = 0; k < 4; k++) begin
            if (g[3*k +: 3] == m[3*k +: 3]) zn++;
            cg[g[3*k +: 3]]++;
            cm[m[3*k +: 3]]++;
        end
        for (int s = 0; s < 8; s++)
            zd += (cg[s] < cm[s]) ? cg[s] : cm[s];
        zd -= zn;
    endfunction

    function automatic bit has_bad(input logic [11:0] g);
        bit b;
        b = 1'b0;
        for (int k = 0; k < 4; k++)
            if (g[3*k +: 3] == 3'd0 || g[3*k +: 3] == 3'd7) b = 1'b1;
        return b;
    endfunction

    // Model: cycles elapsed since capture, results published at +10.
    int          m_cnt = 0;
    logic [11:0] m_g = '0, m_m = '0;
    int          e_zn = 0, e_zd = 0, e_round = 0;
    bit          e_won = 0, e_over = 0, e_done = 0, e_busy = 0, e_bad = 0;

    always @(posedge clk) begin
        int zn, zd;
        if (!reset_L || clear_game) begin
            m_cnt = 0; e_zn = 0; e_zd = 0; e_round = 0;
            e_won = 0; e_over = 0; e_done = 0; e_bad = 0;
        end else begin
            e_done = 0;
            e_bad  = 0;
            if (m_cnt == 0) begin
                if (grade && !e_over) begin
`ifdef GRADER_SHAPE_VALIDATE_EN
                    if (has_bad(guess)) e_bad = 1;
                    else begin
                        m_g = guess; m_m = master; m_cnt = 1;
                    end
`else
                    m_g = guess; m_m = master; m_cnt = 1;
`endif
                end
            end else if (m_cnt < 9) begin
                m_cnt++;
            end else if (m_cnt == 9) begin
                m_cnt = 10;
                score(m_g, m_m, zn, zd);
                e_zn = zn;
                e_zd = zd;
                if (e_round < 15) e_round++;
                if (zn == 4) e_won = 1;
                if (zn == 4 || e_round == MAXR) e_over = 1;
                e_done = 1;
            end else begin
                m_cnt = 0;
            end
        end
        e_busy = (m_cnt >= 1 && m_cnt <= 9);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  int'(busy),         int'(e_busy));
            check("done",  int'(done),         int'(e_done));
            check("znarly", int'(znarly),      e_zn);
            check("zood",  int'(zood),         e_zd);
            check("round", int'(round_number), e_round);
            check("won",   int'(game_won),     int'(e_won));
            check("over",  int'(game_over),    int'(e_over));
            check("bad",   int'(bad_guess),    int'(e_bad));
        end
    end

    task automatic drive_grade(input logic [11:0] g, input logic [11:0] m);
        @(posedge clk); #1;
        guess = g; master = m; grade = 1'b1;
        @(posedge clk); #1;
        grade = 1'b0;
        guess = 12'($urandom);
        master = 12'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt, output int at);
        cnt = 0;
        at = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cnt++;
                at = i;
            end
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; clear_game = 1'b1;
        @(posedge clk); #1; clear_game = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; reset_L = 1'b0;
        @(posedge clk); #1; reset_L = 1'b1;
    endtask

    initial begin
        int zn, zd, lat, cnt, at, seen;
        logic [11:0] mst, g;

        score(12'o1234, 12'o1234, zn, zd);
        check("pin_full_zn", zn, 4);
        check("pin_full_zd", zd, 0);
        score(12'o4321, 12'o1234, zn, zd);
        check("pin_perm_zd", zd, 4);
        score(12'o1311, 12'o1123, zn, zd);
        check("pin_mix_zn", zn, 1);
        check("pin_mix_zd", zd, 2);

        @(posedge clk); #1; chk_en = 1'b1;
        @(posedge clk); #1; reset_L = 1'b1;

        drive_grade(12'o1234, 12'o1234);
        wait_done(lat);
        check("full_lat", lat, 10);
        check("full_zn", int'(znarly), 4);
        check("full_zd", int'(zood), 0);
        check("full_round", int'(round_number), 1);
        check("full_won", int'(game_won), 1);
        check("full_over", int'(game_over), 1);

        pulse_clear();
        drive_grade(12'o4321, 12'o1234);
        wait_done(lat);
        check("perm_zn", int'(znarly), 0);
        check("perm_zd", int'(zood), 4);
        drive_grade(12'o1311, 12'o1123);
        wait_done(lat);
        check("mix_zn", int'(znarly), 1);
        check("mix_zd", int'(zood), 2);
        check("mix_round", int'(round_number), 2);

        pulse_clear();
        for (int r = 0; r < MAXR; r++) begin
            drive_grade(12'o1111, 12'o1234);
            wait_done(lat);
        end
        check("exh_over", int'(game_over), 1);
        check("exh_won", int'(game_won), 0);
        check("exh_round", int'(round_number), MAXR);
        drive_grade(12'o1234, 12'o1234);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        check("exh_ignored", seen, 0);

        pulse_clear();
        drive_grade(12'o1122, 12'o2211);
        repeat (3) @(posedge clk);
        #1; grade = 1'b1;
        @(posedge clk); #1; grade = 1'b0;
        count_done(20, cnt, at);
        check("busy_grade_cnt", cnt, 1);
        check("busy_grade_at", at, 5);
        check("busy_grade_zd", int'(zood), 4);

        drive_grade(12'o1234, 12'o1111);
        repeat (4) @(posedge clk);
        #1; clear_game = 1'b1;
        @(posedge clk); #1; clear_game = 1'b0;
        count_done(15, cnt, at);
        check("clear_nodone", cnt, 0);
        check("clear_round", int'(round_number), 0);

        drive_grade(12'o2222, 12'o2323);
        repeat (2) @(posedge clk);
        #1; reset_L = 1'b0;
        @(posedge clk); #1; reset_L = 1'b1;
        count_done(15, cnt, at);
        check("rst_nodone", cnt, 0);
        drive_grade(12'o3333, 12'o1234);
        wait_done(lat);
        check("rst_lat", lat, 10);
        check("rst_round", int'(round_number), 1);
        check("rst_zn", int'(znarly), 1);
        check("rst_zd", int'(zood), 0);

`ifdef GRADER_SHAPE_VALIDATE_EN
        pulse_clear();
        drive_grade(12'o1704, 12'o1234);
        check("val_bad", int'(bad_guess), 1);
        count_done(12, cnt, at);
        check("val_nodone", cnt, 0);
        check("val_round", int'(round_number), 0);
`endif

        pulse_clear();
        mst = 12'($urandom);
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                g = ($urandom_range(0, 3) == 0) ? mst : 12'($urandom);
                drive_grade(g, mst);
                repeat ($urandom_range(0, 12)) @(posedge clk);
            end else if (r < 80) begin
                pulse_clear();
                mst = 12'($urandom);
            end else if (r < 85) begin
                pulse_reset();
                mst = 12'($urandom);
            end else begin
                repeat ($urandom_range(0, 12)) @(posedge clk);
            end
        end
        repeat (12) @(posedge clk);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
